// File: rtl/regfile_param.sv
// regfile_param: parametrised CPU register file.
//   Two combinational read ports, one synchronous byte-masked write port,
//   optional hardwired-zero entry 0, optional same-cycle write-to-read bypass,
//   and a reset-triggered clear sweep that zeroes one entry per clock.
//
// Ports:
//   Clk     in   1         clock, all state changes on the rising edge
//   Reset   in   1         synchronous active-high reset, restarts the sweep
//   RA, RB  in   ADDR_W    read addresses
//   RW      in   ADDR_W    write address
//   BusW    in   WIDTH     write data
//   RegWr   in   1         write enable
//   ByteEn  in   WIDTH/8   per-byte write mask, bit i covers BusW[8i+7:8i]
//   BusA    out  WIDTH     read data, port A (combinational)
//   BusB    out  WIDTH     read data, port B (combinational)
//   Busy    out  1         high while the clear sweep owns the array
module regfile_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [ADDR_W-1:0]    RA,
    input  logic [ADDR_W-1:0]    RB,
    input  logic [ADDR_W-1:0]    RW,
    input  logic [WIDTH-1:0]     BusW,
    input  logic                 RegWr,
    input  logic [WIDTH/8-1:0]   ByteEn,
    output logic [WIDTH-1:0]     BusA,
    output logic [WIDTH-1:0]     BusB,
    output logic                 Busy
);

    localparam int unsigned NBYTES = WIDTH / 8;
    // One extra bit so that DEPTH == 2**ADDR_W is representable.
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } stateType;

    stateType          state;
    stateType          nextState;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  nextPtr;
    logic              clearEn;
    logic              writeEn;

    logic [WIDTH-1:0]  regs [DEPTH];

    // True when the address maps onto a physical entry.
    function automatic logic inRange(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < DEPTH_P;
    endfunction

    // True when the address names the hardwired-zero entry.
    function automatic logic isZeroEntry(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Enabled bytes from newData, the rest from oldData.
    function automatic logic [WIDTH-1:0] mergeBytes(
        input logic [WIDTH-1:0]  oldData,
        input logic [WIDTH-1:0]  newData,
        input logic [NBYTES-1:0] en
    );
        logic [WIDTH-1:0] result;
        result = oldData;
        for (int i = 0; i < NBYTES; i++) begin
            if (en[i]) begin
                result[8*i +: 8] = newData[8*i +: 8];
            end
        end
        return result;
    endfunction

    // State and sweep pointer register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= nextState;
            ptr   <= nextPtr;
        end
    end

    // Sweep sequencing: one entry per edge, leave CLEAR after the last entry.
    always_comb begin
        nextState = state;
        nextPtr   = ptr;
        clearEn   = 1'b0;
        case (state)
            CLEAR: begin
                clearEn = !Reset;
                nextPtr = ptr + PTR_W'(1);
                if (ptr == LAST_PTR) begin
                    nextState = READY;
                end
            end
            READY: begin
                nextPtr = ptr;
            end
            default: begin
                nextState = CLEAR;
            end
        endcase
    end

    // Reset beats a simultaneous write; writes are only legal when READY.
    always_comb begin
        writeEn = (state == READY) && !Reset && RegWr
                  && inRange(RW) && !isZeroEntry(RW);
    end

    // Storage: the sweep has priority, otherwise apply the byte-masked write.
    always_ff @(posedge Clk) begin
        if (clearEn) begin
            regs[IDX_W'(ptr)] <= '0;
        end else if (writeEn) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (ByteEn[i]) begin
                    regs[IDX_W'(RW)][8*i +: 8] <= BusW[8*i +: 8];
                end
            end
        end
    end

    // Read port A with optional forwarding of the write in flight.
    always_comb begin
        BusA = '0;
        if ((state == READY) && inRange(RA) && !isZeroEntry(RA)) begin
            BusA = regs[IDX_W'(RA)];
            if ((BYPASS != 0) && writeEn && (RW == RA)) begin
                BusA = mergeBytes(BusA, BusW, ByteEn);
            end
        end
    end

    // Read port B, same rules as port A.
    always_comb begin
        BusB = '0;
        if ((state == READY) && inRange(RB) && !isZeroEntry(RB)) begin
            BusB = regs[IDX_W'(RB)];
            if ((BYPASS != 0) && writeEn && (RW == RB)) begin
                BusB = mergeBytes(BusB, BusW, ByteEn);
            end
        end
    end

    always_comb begin
        Busy = (state == CLEAR);
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances sharing stimulus.
//   dut0: DEPTH=32, ZERO_REG=1, BYPASS=1
//   dut1: DEPTH=16, ZERO_REG=0, BYPASS=0
module tb_regfile_param;

    logic        Clk;
    logic        Reset;
    logic [4:0]  RA, RB, RW;
    logic [31:0] BusW;
    logic        RegWr;
    logic [3:0]  ByteEn;

    logic [31:0] busA0, busB0, busA1, busB1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;

    regfile_param #(
        .WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
    ) dut0 (
        .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .RW(RW), .BusW(BusW),
        .RegWr(RegWr), .ByteEn(ByteEn), .BusA(busA0), .BusB(busB0), .Busy(busy0)
    );

    regfile_param #(
        .WIDTH(32), .DEPTH(16), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)
    ) dut1 (
        .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .RW(RW), .BusW(BusW),
        .RegWr(RegWr), .ByteEn(ByteEn), .BusA(busA1), .BusB(busB1), .Busy(busy1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: contents per instance plus edges left in the sweep.
    int          dep [2] = '{32, 16};
    bit          zr  [2] = '{1'b1, 1'b0};
    bit          bp  [2] = '{1'b1, 1'b0};
    logic [31:0] mem [2][32];
    int          left [2] = '{0, 0};
    bit          modelValid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] e);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (e[b]) r[8*b +: 8] = n[8*b +: 8];
        end
        return r;
    endfunction

    function automatic bit wrHolds(input int k);
        return (left[k] == 0) && RegWr && !Reset && (int'(RW) < dep[k])
               && !(zr[k] && (RW == 5'd0));
    endfunction

    function automatic logic [31:0] expRead(input int k, input logic [4:0] addr);
        logic [31:0] v;
        if (left[k] > 0) return 32'h0;
        if ((int'(addr) >= dep[k]) || (zr[k] && (addr == 5'd0))) return 32'h0;
        v = mem[k][addr];
        if (bp[k] && wrHolds(k) && (RW == addr)) v = merge(v, BusW, ByteEn);
        return v;
    endfunction

    // Model update on every rising edge.
    always @(posedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                left[k] = dep[k];
            end else if (left[k] > 0) begin
                left[k]--;
                if (left[k] == 0) begin
                    for (int j = 0; j < 32; j++) mem[k][j] = 32'h0;
                end
            end else if (wrHolds(k)) begin
                mem[k][RW] = merge(mem[k][RW], BusW, ByteEn);
            end
        end
        if (Reset) modelValid = 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (modelValid) begin
            check("busy0", 32'(busy0), 32'(left[0] > 0));
            check("busy1", 32'(busy1), 32'(left[1] > 0));
            check("busA0", busA0, expRead(0, RA));
            check("busB0", busB0, expRead(0, RB));
            check("busA1", busA1, expRead(1, RA));
            check("busB1", busB1, expRead(1, RB));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Count edges after Reset falls until each Busy drops; -1 if it never does.
    task automatic countSweep(output int n0, output int n1);
        n0 = -1;
        n1 = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (n0 < 0 && !busy0) n0 = c;
            if (n1 < 0 && !busy1) n1 = c;
            if (n0 >= 0 && n1 >= 0) break;
        end
    endtask

    initial begin
        int n0, n1;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 32; j++) mem[k][j] = 32'h0;
        Reset = 1'b1; RA = '0; RB = '0; RW = '0; BusW = '0; RegWr = 1'b0; ByteEn = '0;

        // Initial reset and sweep.
        tick(); tick();
        check("busy0_in_reset", 32'(busy0), 32'd1);
        check("busA0_in_reset", busA0, 32'h0);
        Reset = 1'b0;
        countSweep(n0, n1);
        check("sweep0_len_first", n0, 32);
        check("sweep1_len_first", n1, 16);

        // Preload entries 1..10, then sweep them away.
        for (int i = 1; i <= 10; i++) begin
            RegWr = 1'b1; RW = 5'(i); ByteEn = 4'hF; BusW = 32'h1000_0000 + i;
            tick();
        end
        RegWr = 1'b0; RA = 5'd3; RB = 5'd10;
        #2;
        check("preload_a0", busA0, 32'h1000_0003);
        check("preload_b1", busB1, 32'h1000_000A);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        countSweep(n0, n1);
        check("sweep0_len", n0, 32);
        check("sweep1_len", n1, 16);
        for (int a = 0; a < 32; a++) begin
            RA = 5'(a); RB = 5'(31 - a);
            #2;
            check("scan_a0", busA0, 32'h0);
            check("scan_a1", busA1, 32'h0);
            tick();
        end

        // Byte-masked write.
        RegWr = 1'b1; RW = 5'd5; BusW = 32'hAABBCCDD; ByteEn = 4'b1111;
        tick();
        BusW = 32'h11223344; ByteEn = 4'b0101;
        tick();
        RegWr = 1'b0; RA = 5'd5;
        #2;
        check("bytemask_a0", busA0, 32'hAA22CC44);
        check("bytemask_a1", busA1, 32'hAA22CC44);
        tick();

        // All-zero ByteEn is a no-op.
        RegWr = 1'b1; RW = 5'd5; BusW = 32'h0; ByteEn = 4'b0000;
        tick();
        RegWr = 1'b0;
        #2;
        check("noop_a0", busA0, 32'hAA22CC44);

        // Bypass: dut0 forwards, dut1 shows the old value until after the edge.
        RegWr = 1'b1; RW = 5'd7; RA = 5'd7; RB = 5'd7; BusW = 32'hDEADBEEF; ByteEn = 4'hF;
        #2;
        check("bypass_a0", busA0, 32'hDEADBEEF);
        check("bypass_b0", busB0, 32'hDEADBEEF);
        check("nobypass_a1", busA1, 32'h0);
        check("nobypass_b1", busB1, 32'h0);
        tick();
        RegWr = 1'b0;
        #2;
        check("after_a1", busA1, 32'hDEADBEEF);
        check("after_b1", busB1, 32'hDEADBEEF);

        // Zero register.
        RegWr = 1'b1; RW = 5'd0; RA = 5'd0; BusW = 32'hFFFFFFFF; ByteEn = 4'hF;
        #2;
        check("zero_same_a0", busA0, 32'h0);
        tick();
        RegWr = 1'b0;
        #2;
        check("zero_after_a0", busA0, 32'h0);
        check("nonzero_after_a1", busA1, 32'hFFFFFFFF);

        // Reset mid-sweep, with writes attempted while busy.
        Reset = 1'b1;
        tick();
        Reset = 1'b0; RegWr = 1'b1; RW = 5'd3; BusW = 32'h12345678; ByteEn = 4'hF;
        repeat (9) tick();
        Reset = 1'b1; RegWr = 1'b0;
        tick();
        Reset = 1'b0;
        countSweep(n0, n1);
        check("restart0_len", n0, 32);
        check("restart1_len", n1, 16);
        RA = 5'd3;
        #2;
        check("busywrite_a0", busA0, 32'h0);
        check("busywrite_a1", busA1, 32'h0);
        tick();

        // Out-of-range for dut1 (in range for dut0).
        RegWr = 1'b1; RW = 5'd20; RA = 5'd20; BusW = 32'hCAFEF00D; ByteEn = 4'hF;
        #2;
        check("oor_a1", busA1, 32'h0);
        check("oor_bypass_a0", busA0, 32'hCAFEF00D);
        tick();
        RegWr = 1'b0;
        #2;
        check("oor_after_a1", busA1, 32'h0);
        check("oor_after_a0", busA0, 32'hCAFEF00D);
        for (int a = 0; a < 16; a++) begin
            RA = 5'(a);
            #2;
            check("oor_scan_a1", busA1, 32'h0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
